booth_seq_multiplier: RTL and testbench

//  Sequential signed Booth multiplier for the ALU MUL path: the inverse operation of the divider.

---
 rtl/mul_pkg.sv | 35 +++
 rtl/booth_recoder.sv | 30 +++
 rtl/booth_seq_multiplier.sv | 132 +++++++++++++
 tb/tb_booth_seq_multiplier.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the sequential Booth multiplier.
// BOOTH_RADIX4_EN selects radix-4 recoding (two multiplier bits per step); radix-2 otherwise.
package mul_pkg;

    localparam int DEFAULT_WIDTH = 32;

`ifdef BOOTH_RADIX4_EN
    localparam bit RADIX4 = 1'b1;
`else
    localparam bit RADIX4 = 1'b0;
`endif

    // Bits retired per step and width of the recoder window {Q[SH-1:0], q_m1}.
    localparam int BOOTH_SHIFT = RADIX4 ? 2 : 1;
    localparam int BOOTH_WIN   = BOOTH_SHIFT + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        NONE,
        ADD1,
        SUB1,
        ADD2,
        SUB2
    } booth_digit_t;

    function automatic int iter_count(input int width, input bit radix4);
        return radix4 ? (width / 2) : width;
    endfunction

endpackage

// File: rtl/booth_recoder.sv
// Purpose: map low multiplier bits plus q_m1 to a Booth digit (radix-4 when BOOTH_RADIX4_EN).
// Latency: purely combinational.
// Backpressure: none; output follows the window every cycle.
module booth_recoder
    import mul_pkg::*;
(
    input  logic [BOOTH_WIN-1:0] bits,
    output booth_digit_t         digit
);

    always_comb begin
        digit = NONE;
`ifdef BOOTH_RADIX4_EN
        case (bits)
            3'b001, 3'b010: digit = ADD1;
            3'b011:         digit = ADD2;
            3'b100:         digit = SUB2;
            3'b101, 3'b110: digit = SUB1;
            default:        digit = NONE;
        endcase
`else
        case (bits)
            2'b01:   digit = ADD1;
            2'b10:   digit = SUB1;
            default: digit = NONE;
        endcase
`endif
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Purpose: sequential signed Booth multiplier, WIDTH x WIDTH -> 2*WIDTH split into hi/lo (BOOTH_RADIX4_EN: radix-4).
// Latency: start accepted at edge N, done and product valid after edge N+ITER (ITER = WIDTH or WIDTH/2).
// Backpressure: start is only sampled in IDLE/DONE; busy stalls the requester while RUN iterates.
module booth_seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo
);

    localparam int ITER = iter_count(WIDTH, RADIX4);
    localparam int SH   = BOOTH_SHIFT;
    // Extra headroom bits keep -M and -2M of the most negative operand representable.
    localparam int AW   = WIDTH + SH;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    state_t            state;
    logic [AW-1:0]     acc;
    logic [WIDTH-1:0]  q_reg;
    logic [WIDTH-1:0]  m_reg;
    logic              q_m1;
    logic [CW-1:0]     cnt;

    booth_digit_t      digit;
    logic [AW-1:0]     m_ext;
    logic [AW-1:0]     addend;
    logic              sub;
    logic [AW-1:0]     sum;
    logic [AW+WIDTH-1:0] shifted;
    logic [AW-1:0]     acc_next;
    logic [WIDTH-1:0]  q_next;
    logic              accept;
    logic              last_step;

    booth_recoder u_recoder (
        .bits  ({q_reg[SH-1:0], q_m1}),
        .digit (digit)
    );

    assign m_ext = {{SH{m_reg[WIDTH-1]}}, m_reg};

    always_comb begin
        addend = '0;
        sub    = 1'b0;
        case (digit)
            ADD1: addend = m_ext;
            SUB1: begin
                addend = m_ext;
                sub    = 1'b1;
            end
            ADD2: addend = m_ext << 1;
            SUB2: begin
                addend = m_ext << 1;
                sub    = 1'b1;
            end
            default: begin
                addend = '0;
                sub    = 1'b0;
            end
        endcase
    end

    // Subtraction as add of the one's complement plus carry-in.
    assign sum      = acc + (addend ^ {AW{sub}}) + {{(AW-1){1'b0}}, sub};
    assign shifted  = $unsigned($signed({sum, q_reg}) >>> SH);
    assign acc_next = shifted[AW+WIDTH-1:WIDTH];
    assign q_next   = shifted[WIDTH-1:0];

    assign accept    = start && (state != RUN);
    assign last_step = (cnt == CW'(ITER - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            product_hi <= '0;
            product_lo <= '0;
            acc        <= '0;
            q_reg      <= '0;
            m_reg      <= '0;
            q_m1       <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        m_reg <= multiplicand;
                        q_reg <= multiplier;
                        acc   <= '0;
                        q_m1  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    q_reg <= q_next;
                    q_m1 <= q_reg[SH-1];
                    cnt  <= cnt + 1'b1;
                    if (last_step) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        product_hi <= acc_next[WIDTH-1:0];
                        product_lo <= q_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed and random checks of booth_seq_multiplier: reset, latency, ignored start, restart, abort.
module tb_booth_seq_multiplier;

`ifdef BOOTH_RADIX4_EN
    localparam int ITER = 16;
`else
    localparam int ITER = 32;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] product_hi;
    logic [31:0] product_lo;

    int checks   = 0;
    int failures = 0;

    booth_seq_multiplier #(.WIDTH(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product_hi   (product_hi),
        .product_lo   (product_lo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Counts busy cycles until done rises or the budget runs out.
    task automatic wait_done(output int bcyc);
        int n;
        n    = 0;
        bcyc = 0;
        while (done !== 1'b1 && n < ITER + 10) begin
            if (busy === 1'b1) bcyc++;
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] m, input logic [31:0] q,
                          input logic [63:0] exp, input bit glitch);
        int bc;
        int pre;
        pre          = 0;
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        tick();
        start = 1'b0;
        if (glitch) begin
            tick();
            tick();
            multiplicand = 32'h1234_5678;
            multiplier   = 32'h0000_0003;
            start        = 1'b1;
            tick();
            start = 1'b0;
            chk({tag, "_busy_after_glitch"}, {63'd0, busy}, 64'd1);
            pre = 3;
        end
        wait_done(bc);
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        chk({tag, "_latency"}, 64'(bc + pre), 64'(ITER));
        chk({tag, "_busy_in_done"}, {63'd0, busy}, 64'd0);
        chk({tag, "_product"}, {product_hi, product_lo}, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         bc;
        bit         seen_done;
        logic [63:0] held;
        logic [31:0] rm;
        logic [31:0] rq;
        logic signed [63:0] ref_p;

        reset        = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_product", {product_hi, product_lo}, 64'd0);

        run_op("m7_qm3", 32'd7, 32'hFFFF_FFFD, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 1'b0);
        tick();
        chk("m7_done_pulse", {63'd0, done}, 64'd0);
        chk("m7_hold", {product_hi, product_lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});

        run_op("minmin", 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0000_0000}, 1'b0);
        tick();
        run_op("min_x1", 32'h8000_0000, 32'h0000_0001, {32'hFFFF_FFFF, 32'h8000_0000}, 1'b0);
        tick();

        run_op("maxmax_glitch", 32'h7FFF_FFFF, 32'h7FFF_FFFF, {32'h3FFF_FFFF, 32'h0000_0001}, 1'b1);

        // Restart straight out of DONE; the previous product must hold until the new one lands.
        held         = {product_hi, product_lo};
        multiplicand = 32'hFFFF_FFFF;
        multiplier   = 32'hFFFF_FFFF;
        start        = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        chk("b2b_done_drop", {63'd0, done}, 64'd0);
        chk("b2b_held", {product_hi, product_lo}, held);
        wait_done(bc);
        chk("b2b_done", {63'd0, done}, 64'd1);
        chk("b2b_latency", 64'(bc), 64'(ITER));
        chk("b2b_product", {product_hi, product_lo}, {32'h0000_0000, 32'h0000_0001});
        tick();

        // Abort in the fifth RUN cycle.
        multiplicand = 32'd99;
        multiplier   = 32'd77;
        start        = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("abort_busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_product", {product_hi, product_lo}, 64'd0);
        seen_done = 1'b0;
        repeat (ITER + 4) begin
            if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
            tick();
        end
        chk("abort_quiet", {63'd0, seen_done}, 64'd0);

        run_op("m12345", 32'd12345, 32'hFFFF_E57B, {32'hFFFF_FFFF, 32'hFB01_2863}, 1'b0);
        tick();

        for (int i = 0; i < 24; i++) begin
            rm = $urandom;
            rq = $urandom;
            if (i == 0) rm = 32'h8000_0000;
            if (i == 1) rq = 32'h8000_0000;
            if (i == 2) rq = 32'hFFFF_FFFF;
            ref_p = $signed({{32{rm[31]}}, rm}) * $signed({{32{rq[31]}}, rq});
            run_op("random", rm, rq, ref_p, 1'b0);
            tick();
            chk("random_done_pulse", {63'd0, done}, 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
